// File: rtl/proc_job_driver_pkg.sv
// Shared types and constants for the permutation-engine job driver:
// coordinate width, legal coordinate limits, FSM encoding and the job record.
package proc_job_driver_pkg;

    // Width of each engine coordinate (X, Y, Z)
    localparam int COORD_W = 7;

    // Width of one packed job record {x, y, z}
    localparam int JOB_W = 3 * COORD_W;

    // Largest legal X and Y coordinates accepted by the engine
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(4);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(4);

    // Issue FSM: pop in IDLE, pulse start in LAUNCH, wait for the done edge,
    // then leave one recovery cycle before the next pop
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } state_t;

    // One queued job as stored in the FIFO
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } job_t;

    // Bits needed for a counter that must be able to hold the value 'timeout'
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/proc_job_driver_job_fifo.sv
// Small synchronous job FIFO (DEPTH entries of one job_t each).
// Pointers wrap naturally because DEPTH is a power of two; the occupancy
// counter distinguishes full from empty when the pointers are equal.
module proc_job_driver_job_fifo
    import proc_job_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  job_t push_data,
    input  logic pop,
    output job_t pop_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    job_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/proc_job_driver.sv
// Job driver for the permutation engine's start/done interface.
// Buffers (X,Y,Z) jobs from the host, rejects out-of-range coordinates,
// launches one job at a time with a single-cycle start pulse, and retires it
// on the rising edge of doneIn or after TIMEOUT wait cycles.
module proc_job_driver
    import proc_job_driver_pkg::*;
#(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    input  logic [COORD_W-1:0] job_x,
    input  logic [COORD_W-1:0] job_y,
    input  logic [COORD_W-1:0] job_z,
    output logic               job_ready,
    output logic               start,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic [COORD_W-1:0] Z,
    input  logic               doneIn,
    output logic               busy,
    output logic [7:0]         jobs_done,
    output logic               drop_err,
    output logic               timeout_err,
    input  logic               clr_err
);

    localparam int TMO_W = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_LIM = TMO_W'(TIMEOUT);
    // Z must stay below 16*N; one extra bit keeps the limit itself representable
    localparam logic [COORD_W:0]   Z_LIM   = (COORD_W + 1)'(16 * N);

    state_t           state;
    logic             done_q;
    logic             done_rise;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;
    logic             tmo_hit;
    logic             in_range;
    logic             accept;
    logic             push;
    logic             pop;
    logic             drop_evt;
    logic             tmo_evt;
    logic             fifo_full;
    logic             fifo_empty;
    job_t             in_job;
    job_t             head;

    // Host handshake: ready depends only on FIFO occupancy, never on job_valid
    assign job_ready = !fifo_full;
    assign accept    = job_valid && job_ready;
    assign in_range  = (job_x <= X_MAX) && (job_y <= Y_MAX) && ({1'b0, job_z} < Z_LIM);
    // Out-of-range jobs still complete the handshake but are never stored
    assign push      = accept && in_range;
    assign drop_evt  = accept && !in_range;
    assign in_job    = '{x: job_x, y: job_y, z: job_z};

    // Only the IDLE state dequeues, so the FIFO is never popped while empty
    assign pop       = (state == IDLE) && !fifo_empty;

    // Completion is the rising edge of doneIn; a level left high from the
    // previous job never counts as a new completion
    assign done_rise = doneIn && !done_q;

    // tmo_cnt holds the number of WAIT cycles already spent; the job times
    // out at the end of WAIT cycle number TIMEOUT unless done arrives then
    assign tmo_next  = tmo_cnt + 1'b1;
    assign tmo_hit   = (tmo_next == TMO_LIM);
    assign tmo_evt   = (state == WAIT) && !done_rise && tmo_hit;

    proc_job_driver_job_fifo #(
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_job),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Registered copy of doneIn for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= doneIn;
        end
    end

    // Issue FSM with registered start, busy, coordinates, timeout counter and completion count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            start     <= 1'b0;
            busy      <= 1'b0;
            X         <= '0;
            Y         <= '0;
            Z         <= '0;
            tmo_cnt   <= '0;
            jobs_done <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    // Coordinates change only here and then hold until the next pop
                    if (pop) begin
                        X     <= head.x;
                        Y     <= head.y;
                        Z     <= head.z;
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    tmo_cnt <= tmo_next;
                    // done takes priority over a timeout in the same cycle
                    if (done_rise) begin
                        jobs_done <= jobs_done + 1'b1;
                        busy      <= 1'b0;
                        state     <= RETIRE;
                    end else if (tmo_hit) begin
                        busy      <= 1'b0;
                        state     <= RETIRE;
                    end
                end
                RETIRE: begin
                    // One-cycle recovery gap for the engine before the next pop
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (drop_evt) begin
                drop_err <= 1'b1;
            end else if (clr_err) begin
                drop_err <= 1'b0;
            end
            if (tmo_evt) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_proc_job_driver.sv
// Self-checking bench for proc_job_driver: directed sequences for the
// multi-cycle behaviour plus a table of coordinate range vectors.
`timescale 1ns/1ps
module tb_proc_job_driver;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 31;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid;
    logic [6:0] job_x;
    logic [6:0] job_y;
    logic [6:0] job_z;
    logic       job_ready;
    logic       start;
    logic [6:0] X;
    logic [6:0] Y;
    logic [6:0] Z;
    logic       doneIn;
    logic       busy;
    logic [7:0] jobs_done;
    logic       drop_err;
    logic       timeout_err;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    // Start-pulse monitor state
    int         start_cnt  = 0;
    int         low_run    = 1000;
    bit         start_wide = 1'b0;
    bit         hold_viol  = 1'b0;
    bit         gap_viol   = 1'b0;
    logic       prev_start = 1'b0;
    logic [6:0] cap_x      = '0;
    logic [6:0] cap_y      = '0;
    logic [6:0] cap_z      = '0;

    typedef struct {
        logic [6:0] x;
        logic [6:0] y;
        logic [6:0] z;
        logic       drop;
        logic       launches;
    } vec_t;

    vec_t tbl [9];

    proc_job_driver #(
        .N       (N),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_z       (job_z),
        .job_ready   (job_ready),
        .start       (start),
        .X           (X),
        .Y           (Y),
        .Z           (Z),
        .doneIn      (doneIn),
        .busy        (busy),
        .jobs_done   (jobs_done),
        .drop_err    (drop_err),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // Watches start width, start spacing and coordinate hold while busy
    always @(posedge clk) begin
        if (start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            cap_x     <= X;
            cap_y     <= Y;
            cap_z     <= Z;
            if (prev_start === 1'b1) start_wide <= 1'b1;
            if (low_run < 3) gap_viol <= 1'b1;
            low_run   <= 0;
        end else begin
            low_run <= low_run + 1;
            if (busy === 1'b1 && (X !== cap_x || Y !== cap_y || Z !== cap_z))
                hold_viol <= 1'b1;
        end
        prev_start <= start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_job(input logic [6:0] x, input logic [6:0] y, input logic [6:0] z);
        job_x     = x;
        job_y     = y;
        job_z     = z;
        job_valid = 1'b1;
        for (int i = 0; i < 50 && !job_ready; i++) tick();
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_start_lvl(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_cnt(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (start_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_done();
        doneIn = 1'b1;
        tick();
        doneIn = 1'b0;
    endtask

    initial begin
        bit ok;
        bit stable;
        bit seen;
        int base;
        int jd_exp;

        rst       = 1'b0;
        job_valid = 1'b0;
        job_x     = '0;
        job_y     = '0;
        job_z     = '0;
        doneIn    = 1'b0;
        clr_err   = 1'b0;

        tbl[0] = '{x: 7'd5,   y: 7'd0,   z: 7'd0,   drop: 1'b1, launches: 1'b0};
        tbl[1] = '{x: 7'd0,   y: 7'd0,   z: 7'd64,  drop: 1'b1, launches: 1'b0};
        tbl[2] = '{x: 7'd4,   y: 7'd4,   z: 7'd63,  drop: 1'b0, launches: 1'b1};
        tbl[3] = '{x: 7'd0,   y: 7'd5,   z: 7'd0,   drop: 1'b1, launches: 1'b0};
        tbl[4] = '{x: 7'd0,   y: 7'd0,   z: 7'd0,   drop: 1'b0, launches: 1'b1};
        tbl[5] = '{x: 7'd127, y: 7'd127, z: 7'd127, drop: 1'b1, launches: 1'b0};
        tbl[6] = '{x: 7'd4,   y: 7'd0,   z: 7'd0,   drop: 1'b0, launches: 1'b1};
        tbl[7] = '{x: 7'd3,   y: 7'd2,   z: 7'd65,  drop: 1'b1, launches: 1'b0};
        tbl[8] = '{x: 7'd0,   y: 7'd4,   z: 7'd1,   drop: 1'b0, launches: 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_start",       32'(start),       32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_jobs_done",   32'(jobs_done),   32'd0);
        check("rst_drop_err",    32'(drop_err),    32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_job_ready",   32'(job_ready),   32'd1);
        check("rst_xyz",         32'({X, Y, Z}),   32'd0);
        rst = 1'b1;
        tick();

        // Single job (1,2,3), done 20 cycles after start
        push_job(7'd1, 7'd2, 7'd3);
        wait_start_lvl(ok);
        check("t1_start_seen", 32'(ok), 32'd1);
        check("t1_x", 32'(X), 32'd1);
        check("t1_y", 32'(Y), 32'd2);
        check("t1_z", 32'(Z), 32'd3);
        check("t1_busy_launch", 32'(busy), 32'd1);
        stable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) check("t1_start_one_cycle", 32'(start), 32'd0);
            if (X !== 7'd1 || Y !== 7'd2 || Z !== 7'd3) stable = 1'b0;
        end
        check("t1_xyz_stable", 32'(stable), 32'd1);
        check("t1_busy_wait", 32'(busy), 32'd1);
        doneIn = 1'b1;
        tick();
        doneIn = 1'b0;
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_jobs_done", 32'(jobs_done), 32'd1);
        tick();
        tick();

        // Engine never answers: timeout at the end of WAIT cycle TMO
        push_job(7'd0, 7'd1, 7'd2);
        wait_start_lvl(ok);
        check("t2_start_seen", 32'(ok), 32'd1);
        for (int i = 0; i < TMO; i++) tick();
        check("t2_no_err_yet", 32'(timeout_err), 32'd0);
        check("t2_busy_yet",   32'(busy),        32'd1);
        tick();
        check("t2_timeout_err", 32'(timeout_err), 32'd1);
        check("t2_busy_off",    32'(busy),        32'd0);
        check("t2_jobs_done",   32'(jobs_done),   32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t2_clr", 32'(timeout_err), 32'd0);

        // done edge in the same WAIT cycle the counter expires: done wins
        push_job(7'd2, 7'd2, 7'd2);
        wait_start_lvl(ok);
        check("t3_start_seen", 32'(ok), 32'd1);
        for (int i = 0; i < TMO; i++) tick();
        doneIn = 1'b1;
        tick();
        doneIn = 1'b0;
        check("t3_no_timeout", 32'(timeout_err), 32'd0);
        check("t3_jobs_done",  32'(jobs_done),   32'd2);
        check("t3_busy_off",   32'(busy),        32'd0);
        tick();
        tick();

        // doneIn left high after job A must not complete job B
        push_job(7'd1, 7'd1, 7'd1);
        push_job(7'd2, 7'd2, 7'd2);
        wait_start_lvl(ok);
        check("t4_start_a", 32'(ok), 32'd1);
        tick();
        tick();
        doneIn = 1'b1;
        tick();
        check("t4_done_a", 32'(jobs_done), 32'd3);
        wait_start_lvl(ok);
        check("t4_start_b", 32'(ok), 32'd1);
        check("t4_x_b", 32'(X), 32'd2);
        for (int i = 0; i < 8; i++) tick();
        check("t4_no_false_count", 32'(jobs_done), 32'd3);
        check("t4_still_busy",     32'(busy),      32'd1);
        doneIn = 1'b0;
        tick();
        doneIn = 1'b1;
        tick();
        doneIn = 1'b0;
        check("t4_done_b", 32'(jobs_done), 32'd4);
        tick();
        tick();

        // Five jobs with a stalled engine: FIFO fills, then all retire in order
        base = start_cnt;
        for (int i = 0; i < 5; i++) push_job(7'(i), 7'(4 - i), 7'(10 * i + 5));
        check("t5_ready_low_full", 32'(job_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_cnt(base + i + 1, ok);
            check("t5_start_seen", 32'(ok), 32'd1);
            check("t5_x", 32'(X), 32'(i));
            check("t5_y", 32'(Y), 32'(4 - i));
            check("t5_z", 32'(Z), 32'(10 * i + 5));
            if (i == 1) check("t5_ready_after_pop", 32'(job_ready), 32'd1);
            pulse_done();
        end
        tick();
        tick();
        tick();
        check("t5_jobs_done", 32'(jobs_done), 32'd9);

        // Coordinate range table
        jd_exp = 9;
        for (int v = 0; v < 9; v++) begin
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            check("tv_drop_cleared", 32'(drop_err), 32'd0);
            base = start_cnt;
            push_job(tbl[v].x, tbl[v].y, tbl[v].z);
            check("tv_drop_err", 32'(drop_err), 32'(tbl[v].drop));
            seen = 1'b0;
            for (int i = 0; i < 6 && !seen; i++) begin
                tick();
                if (start_cnt > base) seen = 1'b1;
            end
            check("tv_launch", 32'(seen), 32'(tbl[v].launches));
            if (seen) begin
                check("tv_xyz", 32'({X, Y, Z}), 32'({tbl[v].x, tbl[v].y, tbl[v].z}));
                pulse_done();
                jd_exp++;
            end
            tick();
            tick();
            tick();
            check("tv_jobs_done", 32'(jobs_done), 32'(jd_exp));
        end

        // Clear and a new drop in the same cycle: the set wins
        job_x     = 7'd5;
        job_y     = 7'd0;
        job_z     = 7'd0;
        job_valid = 1'b1;
        clr_err   = 1'b1;
        tick();
        job_valid = 1'b0;
        clr_err   = 1'b0;
        check("tc_set_wins", 32'(drop_err), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("tc_clear", 32'(drop_err), 32'd0);
        tick();

        // Asynchronous reset during WAIT with two jobs queued
        push_job(7'd0, 7'd0, 7'd1);
        push_job(7'd0, 7'd0, 7'd2);
        push_job(7'd0, 7'd0, 7'd3);
        check("tr_busy_before", 32'(busy), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("tr_start",     32'(start),     32'd0);
        check("tr_busy",      32'(busy),      32'd0);
        check("tr_jobs_done", 32'(jobs_done), 32'd0);
        check("tr_job_ready", 32'(job_ready), 32'd1);
        tick();
        rst  = 1'b1;
        base = start_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("tr_no_start_after", 32'(start_cnt - base), 32'd0);
        check("tr_busy_after",     32'(busy),             32'd0);

        // Whole-run monitor results
        check("mon_start_width", 32'(start_wide), 32'd0);
        check("mon_xyz_hold",    32'(hold_viol),  32'd0);
        check("mon_start_gap",   32'(gap_viol),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
